// File: rtl/reg_bank_write_demux_pkg.sv
// Shared constants and the address decode for the 16x32 register bank.
// The read side's mux_16 tree uses the same address encoding.
package reg_bank_write_demux_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int REG_COUNT      = 16;
  localparam int ZERO_REG_INDEX = 0;

  // With zero_reg set, the hardwired register never gets an enable.
  function automatic logic [REG_COUNT-1:0] onehot_dec(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic                      en,
    input logic                      zero_reg
  );
    logic [REG_COUNT-1:0] oh;
    oh = '0;
    if (en && !(zero_reg &&
        addr == REG_ADDR_WIDTH'(ZERO_REG_INDEX)))
      oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_bank_write_demux_decoder_4to16.sv
// Combinational 4-to-16 one-hot write-enable decoder.
// Mirror of the read-side mux_16 select tree.
module decoder_4to16
  import reg_bank_write_demux_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      en,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  output logic [REG_COUNT-1:0]      onehot
);

  always_comb begin
    onehot = onehot_dec(addr, en, ZERO_REG);
  end

endmodule

// File: rtl/reg_bank_write_demux.sv
// Write side of the 16x32 register bank: handshake, 2-stage commit pipe,
// register array and flat readback bus.
module reg_bank_write_demux
  import reg_bank_write_demux_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int NUM_REGS   = REG_COUNT,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           hold,
  input  logic                           clr,
  output logic [NUM_REGS-1:0]            commit_we,
  output logic [DATA_WIDTH-1:0]          commit_data,
  output logic                           busy,
  output logic [NUM_REGS*DATA_WIDTH-1:0] q_flat
);

  logic                           s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0]          s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0]          s1_data_q, s1_data_d;
  logic                           s2_valid_q, s2_valid_d;
  logic [NUM_REGS-1:0]            s2_we_q, s2_we_d;
  logic [DATA_WIDTH-1:0]          s2_data_q, s2_data_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

  logic [NUM_REGS-1:0] s1_onehot;
  logic                commit_fire;
  logic                s2_free;
  logic                s1_adv;
  logic                accept;

  decoder_4to16 #(
    .ZERO_REG (ZERO_REG != 0)
  ) u_dec (
    .en     (s1_valid_q),
    .addr   (s1_addr_q),
    .onehot (s1_onehot)
  );

  always_comb begin
    commit_fire = s2_valid_q && !hold && !clr;
    s2_free     = !s2_valid_q || commit_fire;
    s1_adv      = s1_valid_q && s2_free;
    wr_ready    = !clr && (!s1_valid_q || s1_adv);
    accept      = wr_valid && wr_ready;
    commit_we   = commit_fire ? s2_we_q : '0;
    commit_data = commit_fire ? s2_data_q : '0;
    busy        = s1_valid_q || s2_valid_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_we_d    = s2_we_q;
    s2_data_d  = s2_data_q;
    regs_d     = regs_q;
    if (clr) begin
      // Pending writes are dropped, never committed.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      regs_d     = '0;
    end else begin
      if (commit_fire) begin
        s2_valid_d = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (s2_we_q[i])
            regs_d[i*DATA_WIDTH +: DATA_WIDTH] = s2_data_q;
        end
      end
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_we_d    = s1_onehot;
        s2_data_d  = s1_data_q;
        s1_valid_d = 1'b0;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_addr_d  = wr_addr;
        s1_data_d  = wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_we_q    <= '0;
      s2_data_q  <= '0;
      regs_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_we_q    <= s2_we_d;
      s2_data_q  <= s2_data_d;
      regs_q     <= regs_d;
    end
  end

  assign q_flat = regs_q;

endmodule

// File: doc/reg_bank_write_demux.md
Name: reg_bank_write_demux

Overview:
Write side of the 16x32 register bank whose read side is the mux_16 selection tree. Accepts write requests over a valid/ready handshake and decodes the 4-bit address to a one-hot enable. Commits through a two-stage pipeline into 16 32-bit registers and exposes all registers as a flat bus that feeds the read muxes. Supports processor stall (hold) and a bulk clear.

Parameters:
DATA_WIDTH, 32, width of each register
NUM_REGS, 16, number of registers; must equal 2**ADDR_WIDTH
ADDR_WIDTH, 4, write address width
ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are discarded

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_valid  input  1  write request present
wr_ready  output  1  block can accept a request this cycle
wr_addr  input  ADDR_WIDTH  destination register
wr_data  input  DATA_WIDTH  write data
hold  input  1  stall: blocks stage-2 commit while high
clr  input  1  single-cycle bulk clear of all registers and pipeline
commit_we  output  NUM_REGS  one-hot enable of the commit occurring this cycle (forwarding/debug)
commit_data  output  DATA_WIDTH  data being committed this cycle
busy  output  1  stage 1 or stage 2 holds a request
q_flat  output  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (reset=1 at an edge): all registers 0, s1_valid=s2_valid=0. Resulting outputs: wr_ready=1, busy=0, commit_we=0, commit_data=0, q_flat=0. Reset overrides clr, hold and wr_valid.
- Handshake: a transfer occurs when wr_valid && wr_ready at an edge. wr_addr/wr_data are sampled only then. The requester must hold them stable while wr_valid=1 and wr_ready=0.
- Stage 1 (S1): registers addr and data; decodes addr to a one-hot enable. With ZERO_REG=1, address 0 decodes to all-zero.
- Stage 2 (S2): holds the one-hot enable and data. commit_fire = s2_valid && !hold && !clr.
- On commit_fire, reg[i] <= s2_data for the single set bit i. commit_we shows the one-hot and commit_data shows the data in that same cycle. Otherwise both outputs are 0.
- Advance rules:
  - s2_free = !s2_valid || commit_fire
  - s1_adv = s1_valid && s2_free
  - wr_ready = !clr && (!s1_valid || s1_adv)
- Latency: a request accepted at edge N commits at edge N+2 with hold=0; q_flat shows the new value after edge N+2. Full throughput is one write per cycle.
- hold=1: S2 does not commit. S1 advances only if S2 is empty. Once both stages are full, wr_ready=0. Registers are unchanged. Order is preserved on release.
- clr=1 at an edge:
  - all registers go to 0 and s1_valid/s2_valid go to 0; pending writes are discarded, not committed
  - wr_ready=0 during the clr cycle, so no new request is accepted
  - clr takes priority over a simultaneous commit; hold has no effect on clr
- Write to register 0 with ZERO_REG=1: accepted and pipelined normally; commit_we=0 and q_flat[31:0] stays 0. With ZERO_REG=0, register 0 behaves like any other register.
- Back-to-back writes to the same address commit in order; the last value wins.
- busy = s1_valid || s2_valid.
- Widths: no arithmetic; addresses are always in range because NUM_REGS = 2**ADDR_WIDTH.

Decomposition:
- Shared package constants: REG_DATA_WIDTH=32, REG_ADDR_WIDTH=4, REG_COUNT=16, ZERO_REG_INDEX=0. The package also holds a function that decodes an address to a one-hot vector with zero-register suppression.
- One natural sub-module: decoder_4to16. It is a combinational one-hot decoder with an enable input and is the mirror of the mux_16 select tree. It is instantiated in S1.
- The register array and pipeline control stay in the top module.

Test Plan:
- Reset, then write addr=5, data=0xDEADBEEF, hold=0 -> commit_we=0x0020 and commit_data=0xDEADBEEF two edges after acceptance; q_flat[191:160]=0xDEADBEEF; busy=0 afterwards.
- Stream of writes addr 1..15 with data=addr*0x11111111, one per cycle -> wr_ready stays 1; each register equals its value; throughput is 1 per cycle.
- Hold high from cycle 2 while 4 requests are offered -> wr_ready drops after 2 acceptances; no register changes. Release hold -> the accepted writes commit in order, then the remaining 2 requests are accepted and commit.
- Write addr=0, data=0xFFFFFFFF with ZERO_REG=1 -> commit_we=0 and q_flat[31:0]=0. Same test with ZERO_REG=0 -> reg 0 = 0xFFFFFFFF.
- Registers preloaded, two writes in flight, assert clr for 1 cycle -> all q_flat=0; in-flight writes never commit; wr_ready=0 during the clr cycle; busy=0 afterwards.
- Writes to addr=3 of 0xA, then 0xB, then reset asserted mid-pipeline -> all outputs return to reset values and reg 3 = 0.
